// File: rtl/lsu_mem_master.sv
// Load/store initiator: converts CPU byte/half/word accesses into req/ack word accesses (read-modify-write for sub-word stores).
// Optional macro LSU_TIMEOUT_EN aborts a memory phase after TIMEOUT_CYCLES cycles without mem_ack.
module lsu_mem_master #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_rsp_valid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} stateType;

    stateType    state, stateNext;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [1:0]  reqLane;
    logic [15:0] reqWdata;
    logic        accept, illegal, timeoutHit;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData, mergeWord;
    logic        unusedAddr;

    // Address bits above the memory size are ignored, so accesses wrap.
    assign unusedAddr    = ^cpu_addr[31:ADDR_W+2];

    assign cpu_req_ready = (state == IDLE) && !reset;
    assign cpu_rsp_valid = (state == RESP);
    assign mem_req       = state inside {RD, RMW_RD, RMW_WR, WR};
    assign mem_we        = state inside {RMW_WR, WR};
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign illegal       = (cpu_size == 2'b11)
                        || (cpu_size == 2'b01 && cpu_addr[0])
                        || (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;

    // Fires in the cycle whose missing ack would bring the count to TIMEOUT_CYCLES.
    assign timeoutHit = mem_req && !mem_ack && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || stateNext != state) begin
            waitCnt <= '0;
        end else if (mem_req && !mem_ack) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign timeoutHit    = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal)                 stateNext = RESP;
                    else if (!cpu_we)            stateNext = RD;
                    else if (cpu_size == 2'b10)  stateNext = WR;
                    else                         stateNext = RMW_RD;
                end
            end
            RMW_RD: begin
                if (mem_ack)         stateNext = RMW_WR;
                else if (timeoutHit) stateNext = RESP;
            end
            RD, RMW_WR, WR: begin
                if (mem_ack || timeoutHit) stateNext = RESP;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write, both little-endian.
    always_comb begin
        case (reqLane)
            2'd0:    byteSel = mem_rdata[7:0];
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            default: byteSel = mem_rdata[31:24];
        endcase
        halfSel = reqLane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (reqSize)
            2'b00:   loadData = {{24{reqSigned & byteSel[7]}}, byteSel};
            2'b01:   loadData = {{16{reqSigned & halfSel[15]}}, halfSel};
            default: loadData = mem_rdata;
        endcase

        mergeWord = mem_rdata;
        if (reqSize == 2'b00) begin
            case (reqLane)
                2'd0:    mergeWord[7:0]   = reqWdata[7:0];
                2'd1:    mergeWord[15:8]  = reqWdata[7:0];
                2'd2:    mergeWord[23:16] = reqWdata[7:0];
                default: mergeWord[31:24] = reqWdata[7:0];
            endcase
        end else if (reqLane[1]) begin
            mergeWord[31:16] = reqWdata;
        end else begin
            mergeWord[15:0] = reqWdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reqSize   <= '0;
            reqSigned <= 1'b0;
            reqLane   <= '0;
            reqWdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                reqSize   <= cpu_size;
                reqSigned <= cpu_signed;
                reqLane   <= cpu_addr[1:0];
                reqWdata  <= cpu_wdata[15:0];
                mem_addr  <= cpu_addr[ADDR_W+1:2];
                mem_wdata <= cpu_wdata;
                cpu_rdata <= '0;
                cpu_err   <= illegal;
            end
            if (state == RD && mem_ack) begin
                cpu_rdata <= loadData;
            end
            // Sub-word stores write back the read word with only the target lane replaced.
            if (state == RMW_RD && mem_ack) begin
                mem_wdata <= mergeWord;
            end
            if (timeoutHit) begin
                cpu_rdata <= '0;
                cpu_err   <= 1'b1;
            end
        end
    end

endmodule
